// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared constants, colour struct and state enum for the palette lookup
`timescale 1ns/1ps
package palette_pkg;

  localparam int PAL_IDX_W = 8;
  localparam int PAL_CH_W  = 4;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pal_state_e;

endpackage

// File: rtl/palette_ram.sv
// rtl/palette_ram.sv - simple dual-port palette storage, synchronous write, registered read-first read
`timescale 1ns/1ps
module palette_ram
  import palette_pkg::*;
#(
  parameter int ADDR_W = PAL_IDX_W,
  parameter int DATA_W = 3 * PAL_CH_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [1<<ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Nonblocking read of mem_q gives the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/palette_lut.sv
// rtl/palette_lut.sv - palette index to RGB lookup with clear sweep; optional PALETTE_FADE_EN brightness scaling
`timescale 1ns/1ps
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W      = PAL_IDX_W,
  parameter int CH_W       = PAL_CH_W,
  parameter int TRANSP_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              rd_valid,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_transparent,
  input  logic              wr_valid,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_color,
  output logic              wr_ready,
  output logic              init_busy
`ifdef PALETTE_FADE_EN
  ,
  input  logic [CH_W-1:0]   fade_level
`endif
);

  localparam int               ENT_W    = 3 * CH_W;
  localparam logic [IDX_W-1:0] TRANSP_I = IDX_W'(TRANSP_IDX);

  pal_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             init_busy_q, init_busy_d;
  logic             wr_ready_q, wr_ready_d;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [ENT_W-1:0] ram_wdata;
  logic [ENT_W-1:0] ram_rdata;
  logic             rd_accept;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_transp_q, s1_transp_d;
`ifdef PALETTE_FADE_EN
  logic [CH_W-1:0]  s1_fade_q, s1_fade_d;
`endif

  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  red_q, red_d;
  logic [CH_W-1:0]  green_q, green_d;
  logic [CH_W-1:0]  blue_q, blue_d;
  logic             out_transp_q, out_transp_d;

`ifdef PALETTE_FADE_EN
  // c*(f+1) never exceeds 2*CH_W bits, so the shifted product is exact.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c, input logic [CH_W-1:0] f);
    logic [2*CH_W-1:0] p;
    p = (2*CH_W)'(c) * ((2*CH_W)'(f) + (2*CH_W)'(1));
    return CH_W'(p >> CH_W);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase
    init_busy_d = (state_d == ST_INIT);
    wr_ready_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_busy_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_busy_q <= init_busy_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  // The clear sweep owns the write port until RUN; host writes are gated by wr_ready.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_index;
    ram_wdata = wr_color;
    if (state_q == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_q;
      ram_wdata = '0;
    end else if (wr_valid && wr_ready_q) begin
      ram_we = 1'b1;
    end
  end

  assign rd_accept = rd_valid && (state_q == ST_RUN);

  palette_ram #(
    .ADDR_W (IDX_W),
    .DATA_W (ENT_W)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_accept),
    .raddr (rd_index),
    .rdata (ram_rdata)
  );

  always_comb begin
    s1_valid_d  = rd_accept;
    s1_transp_d = (rd_index == TRANSP_I);
`ifdef PALETTE_FADE_EN
    s1_fade_d   = fade_level;
`endif

    out_valid_d  = s1_valid_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    out_transp_d = out_transp_q;
    if (s1_valid_q) begin
      out_transp_d = s1_transp_q;
`ifdef PALETTE_FADE_EN
      red_d   = fade_ch(ram_rdata[3*CH_W-1 -: CH_W], s1_fade_q);
      green_d = fade_ch(ram_rdata[2*CH_W-1 -: CH_W], s1_fade_q);
      blue_d  = fade_ch(ram_rdata[CH_W-1   -: CH_W], s1_fade_q);
`else
      red_d   = ram_rdata[3*CH_W-1 -: CH_W];
      green_d = ram_rdata[2*CH_W-1 -: CH_W];
      blue_d  = ram_rdata[CH_W-1   -: CH_W];
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_transp_q  <= 1'b0;
`ifdef PALETTE_FADE_EN
      s1_fade_q    <= '0;
`endif
      out_valid_q  <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      out_transp_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_transp_q  <= s1_transp_d;
`ifdef PALETTE_FADE_EN
      s1_fade_q    <= s1_fade_d;
`endif
      out_valid_q  <= out_valid_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      out_transp_q <= out_transp_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign red             = red_q;
  assign green           = green_q;
  assign blue            = blue_q;
  assign out_transparent = out_transp_q;
  assign wr_ready        = wr_ready_q;
  assign init_busy       = init_busy_q;

endmodule

// File: tb/tb_palette_lut.sv
// tb/tb_palette_lut.sv - randomized scoreboard bench for palette_lut
`timescale 1ns/1ps
module tb_palette_lut;
  import palette_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        rd_valid;
  logic [7:0]  rd_index;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        out_transparent;
  logic        wr_valid;
  logic [7:0]  wr_index;
  logic [11:0] wr_color;
  logic        wr_ready;
  logic        init_busy;
`ifdef PALETTE_FADE_EN
  logic [3:0]  fade_level;
`endif

  always #5 Clk = ~Clk;

  palette_lut dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .rd_valid        (rd_valid),
    .rd_index        (rd_index),
    .out_valid       (out_valid),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .out_transparent (out_transparent),
    .wr_valid        (wr_valid),
    .wr_index        (wr_index),
    .wr_color        (wr_color),
    .wr_ready        (wr_ready),
    .init_busy       (init_busy)
`ifdef PALETTE_FADE_EN
    ,
    .fade_level      (fade_level)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: palette contents, pending lookups with their due edge, expected outputs.
  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        tr;
  } pend_t;

  pend_t       pend[$];
  logic [11:0] mem_m [256];
  int          ecount    = 0;
  int          rel_edges = 0;
  logic        e_valid = 1'b0, e_tr = 1'b0, e_busy = 1'b1, e_ready = 1'b0;
  logic [11:0] e_rgb = 12'h000;

  wire [16:0] dut_vec = {out_valid, red, green, blue, out_transparent, init_busy, wr_ready};

  function automatic logic [16:0] exp_vec();
    return {e_valid, e_rgb, e_tr, e_busy, e_ready};
  endfunction

  function automatic logic [11:0] fade_rgb(input logic [11:0] c, input logic [3:0] f);
    rgb_t x;
    x = c;
`ifdef PALETTE_FADE_EN
    begin
      int k;
      k = int'(f) + 1;
      return {4'((int'(x.r) * k) / 16), 4'((int'(x.g) * k) / 16), 4'((int'(x.b) * k) / 16)};
    end
`else
    if (f > 4'hF) return 12'h000;
    return {x.r, x.g, x.b};
`endif
  endfunction

  task automatic cycle(input logic rst_n, input logic rv, input logic [7:0] ri,
                       input logic wv, input logic [7:0] wi, input logic [11:0] wc,
                       input logic [3:0] fl);
    logic run;
    pend_t p;
    Reset_n  = rst_n;
    rd_valid = rv;
    rd_index = ri;
    wr_valid = wv;
    wr_index = wi;
    wr_color = wc;
`ifdef PALETTE_FADE_EN
    fade_level = fl;
`endif
    run = (rel_edges >= 256);
    if (!rst_n) begin
      pend.delete();
      rel_edges = 0;
      for (int i = 0; i < 256; i++) mem_m[i] = 12'h000;
    end else begin
      if (rv && run) begin
        p.due = ecount + 2;
        p.rgb = fade_rgb(mem_m[ri], fl);
        p.tr  = (ri == 8'h00);
        pend.push_back(p);
      end
      if (wv && run) mem_m[wi] = wc;
      rel_edges++;
    end
    @(posedge Clk);
    #1;
    ecount++;
    if (!rst_n) begin
      e_valid = 1'b0;
      e_rgb   = 12'h000;
      e_tr    = 1'b0;
    end else if (pend.size() > 0 && pend[0].due == ecount) begin
      e_valid = 1'b1;
      e_rgb   = pend[0].rgb;
      e_tr    = pend[0].tr;
      void'(pend.pop_front());
    end else begin
      e_valid = 1'b0;
    end
    e_ready = rst_n && (rel_edges >= 256);
    e_busy  = !e_ready;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 12'h000, 4'hF);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b1, 8'(i), 12'hFFF, 4'hF);
      n_cmp++;
      if (dut_vec !== {1'b0, 12'h000, 1'b0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_state got=%h want=%h", dut_vec, {1'b0, 12'h000, 1'b0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_init_sweep();
    int  edges;
    logic done;
    edges = 0;
    done  = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            8'($urandom), 12'($urandom), 4'hF);
      edges++;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL init_sweep edge=%0d got=%h want=%h", ecount, dut_vec, exp_vec());
      end
      if (!init_busy) done = 1'b1;
    end
    n_cmp++;
    if (!done || edges != 256) begin
      n_bad++;
      $display("FAIL init_length got=%0d edges (done=%0b) want=256", edges, done);
    end
  endtask

  task automatic test_cleared_read();
    cycle(1'b1, 1'b1, 8'h37, 1'b0, 8'h00, 12'h000, 4'hF);
    idle();
    n_cmp++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'h000}) begin
      n_bad++;
      $display("FAIL cleared_read got=%h want=%h", {out_valid, red, green, blue}, {1'b1, 12'h000});
    end
  endtask

  task automatic test_write_read();
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 12'h69C, 4'hF);
    cycle(1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 12'h000, 4'hF);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL write_read_early got=%b want=0", out_valid);
    end
    idle();
    n_cmp++;
    if ({out_valid, red, green, blue, out_transparent} !== {1'b1, 4'h6, 4'h9, 4'hC, 1'b0}) begin
      n_bad++;
      $display("FAIL write_read got=%h want=%h", {out_valid, red, green, blue, out_transparent},
               {1'b1, 4'h6, 4'h9, 4'hC, 1'b0});
    end
  endtask

  task automatic test_read_first();
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 12'h123, 4'hF);
    cycle(1'b1, 1'b1, 8'h10, 1'b1, 8'h10, 12'hABC, 4'hF);
    cycle(1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 12'h000, 4'hF);
    n_cmp++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'h123}) begin
      n_bad++;
      $display("FAIL read_first_old got=%h want=%h", {out_valid, red, green, blue}, {1'b1, 12'h123});
    end
    idle();
    n_cmp++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'hABC}) begin
      n_bad++;
      $display("FAIL read_first_new got=%h want=%h", {out_valid, red, green, blue}, {1'b1, 12'hABC});
    end
  endtask

`ifdef PALETTE_FADE_EN
  task automatic test_fade();
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 12'hF8E, 4'hF);
    cycle(1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 12'h000, 4'h7);
    cycle(1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 12'h000, 4'hF);
    n_cmp++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'h747}) begin
      n_bad++;
      $display("FAIL fade_7 got=%h want=%h", {out_valid, red, green, blue}, {1'b1, 12'h747});
    end
    idle();
    n_cmp++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'hF8E}) begin
      n_bad++;
      $display("FAIL fade_15 got=%h want=%h", {out_valid, red, green, blue}, {1'b1, 12'hF8E});
    end
  endtask
`endif

  task automatic test_stream();
    int vcount, run_len, max_run, tcount;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'($urandom), 12'($urandom), 4'hF);
    end
    vcount = 0; run_len = 0; max_run = 0; tcount = 0;
    for (int i = 0; i < 258; i++) begin
      if (i < 256) cycle(1'b1, 1'b1, 8'(i), 1'b0, 8'h00, 12'h000, 4'($urandom));
      else idle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL stream_data edge=%0d got=%h want=%h", ecount, dut_vec, exp_vec());
      end
      if (out_valid) begin
        vcount++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (out_transparent) tcount++;
      end else begin
        run_len = 0;
      end
    end
    n_cmp++;
    if (vcount != 256 || max_run != 256 || tcount != 1) begin
      n_bad++;
      $display("FAIL stream_shape got valid=%0d run=%0d transp=%0d want 256/256/1", vcount, max_run, tcount);
    end
  endtask

  task automatic test_random();
    logic [7:0] ri, wi;
    for (int i = 0; i < 600; i++) begin
      ri = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      wi = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      cycle(1'b1, 1'($urandom_range(0, 1)), ri, 1'($urandom_range(0, 1)), wi, 12'($urandom),
            4'($urandom));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_mix edge=%0d got=%h want=%h", ecount, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    int   edges, vseen;
    logic done;
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 12'h69C, 4'hF);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00, 12'h000, 4'hF);
    end
    cycle(1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 12'h000, 4'hF);
    n_cmp++;
    if ({out_valid, init_busy, wr_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL midreset_edge got=%b want=010", {out_valid, init_busy, wr_ready});
    end
    edges = 0; vseen = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00, 12'h000, 4'hF);
      edges++;
      if (out_valid) vseen++;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL midreset_sweep edge=%0d got=%h want=%h", ecount, dut_vec, exp_vec());
      end
      if (!init_busy) done = 1'b1;
    end
    n_cmp++;
    if (!done || edges != 256 || vseen != 0) begin
      n_bad++;
      $display("FAIL midreset_restart got edges=%0d valids=%0d want 256/0", edges, vseen);
    end
    cycle(1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 12'h000, 4'hF);
    idle();
    n_cmp++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'h000}) begin
      n_bad++;
      $display("FAIL midreset_cleared got=%h want=%h", {out_valid, red, green, blue}, {1'b1, 12'h000});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n  = 1'b0;
    rd_valid = 1'b0;
    rd_index = 8'h00;
    wr_valid = 1'b0;
    wr_index = 8'h00;
    wr_color = 12'h000;
`ifdef PALETTE_FADE_EN
    fade_level = 4'hF;
`endif
    test_reset();
    test_init_sweep();
    test_cleared_read();
    test_write_read();
    test_read_first();
`ifdef PALETTE_FADE_EN
    test_fade();
`endif
    test_stream();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 SHALL have parameter IDX_W, 8, palette index width; depth is 2^IDX_W entries.
REQ-002 SHALL have parameter CH_W, 4, bits per colour channel; entry width is 3*CH_W, ordered {R,G,B}.
REQ-003 SHALL have parameter TRANSP_IDX, 0, index flagged as transparent.
REQ-004 SHALL have port Clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports rd_valid  input  1 and rd_index  input  IDX_W: the lookup request.
REQ-007 SHALL have ports out_valid  output  1; red, green, blue  output  CH_W each; out_transparent  output  1.
REQ-008 SHALL have ports wr_valid  input  1; wr_index  input  IDX_W; wr_color  input  3*CH_W; wr_ready  output  1.
REQ-009 SHALL have port init_busy  output  1, high while the palette clear sweep runs.
REQ-010 SHALL have port fade_level  input  CH_W, present only when PALETTE_FADE_EN is defined.

Function
REQ-011 SHALL implement an FSM with two states, INIT and RUN; reset enters INIT with sweep counter 0.
REQ-012 INIT SHALL write 0 to entry counter, one entry per cycle, for 2^IDX_W cycles, then go to RUN; init_busy = (state==INIT).
REQ-013 wr_ready SHALL equal (state==RUN); a write is accepted only on wr_valid && wr_ready and lands in the next cycle.
REQ-014 A read SHALL be accepted only on rd_valid in RUN; rd_valid during INIT is dropped and produces no out_valid.
REQ-015 Lookup latency SHALL be exactly 2 cycles from rd_valid to out_valid, at full throughput (one read per cycle) with order preserved.
REQ-016 out_transparent SHALL be (rd_index == TRANSP_IDX), delayed to align with its out_valid.
REQ-017 Outputs SHALL hold their last value while out_valid is low.
REQ-018 A read and a write to the same index in the same cycle SHALL return the old entry (read-first); the next read returns the new entry.
REQ-019 A read and a write to different indices in the same cycle SHALL both complete without interference.

Reset
REQ-020 While Reset_n is low at a clock edge: out_valid=0, red/green/blue=0, out_transparent=0, wr_ready=0, init_busy=1, pipeline valids cleared.
REQ-021 Reset asserted mid-stream or mid-INIT SHALL discard all in-flight reads and restart the sweep at index 0.

Configuration
REQ-022 With macro PALETTE_FADE_EN defined, each output channel SHALL equal (c * (fade_level+1)) >> CH_W, computed at full precision, within the same 2-cycle latency; fade_level is sampled with the read request.
REQ-023 Without PALETTE_FADE_EN, the fade_level port and multiplier SHALL be absent and the channels SHALL equal the stored values.

Structure
REQ-024 Shared package palette_pkg SHALL hold the default IDX_W/CH_W constants, the rgb struct typedef and the INIT/RUN state enum.
REQ-025 Storage SHALL be a sub-module palette_ram: simple dual-port, one synchronous write port, one registered read-first read port, inferable as block RAM.

Verification
REQ-026 Release reset -> init_busy=1 and wr_ready=0 for 256 cycles, then init_busy=0; read 0x37 -> out_valid 2 cycles later with RGB=0x000.
REQ-027 Write 0x05=0x69C, then read 0x05 -> 2 cycles later red=6, green=9, blue=C, out_valid=1, out_transparent=0.
REQ-028 Entry 0x10=0x123; same-cycle write 0x10=0xABC with read 0x10 -> returns 0x123; read next cycle -> 0xABC.
REQ-029 Stream reads 0x00..0xFF on consecutive cycles -> out_valid high 256 consecutive cycles, data in order, out_transparent=1 only for index 0x00.
REQ-030 PALETTE_FADE_EN with fade_level=7 and entry 0xF8E -> output 0x747; fade_level=15 -> 0xF8E.
REQ-031 Assert Reset_n low mid-stream for 1 cycle -> out_valid=0 at the following edge, no stale data emitted, and the sweep restarts (init_busy=1 for 256 cycles).
